// File: rtl/debounce_bank.sv
// Multi-channel debouncer: two-flop synchronizer, per-channel debounce counter,
// one-cycle press/release pulses and an optional long-press detector.
// Optional feature macro: DEBOUNCE_HOLD_EN (hold counters, hold_out/hold_pulse).
// Without it, hold_out and hold_pulse are tied to 0.
module debounce_bank #(
  parameter int unsigned N           = 20,
  parameter int unsigned DB_CYCLES   = 100000,
  parameter int unsigned HOLD_CYCLES = 200000000,
  parameter logic [N-1:0] INV_MASK   = '0
) (
  input  logic         clk,
  input  logic         rst,
  input  logic [N-1:0] raw_in,
  output logic [N-1:0] level_out,
  output logic [N-1:0] press_pulse,
  output logic [N-1:0] release_pulse,
  output logic [N-1:0] hold_out,
  output logic [N-1:0] hold_pulse
);

  localparam int unsigned DbW = $clog2(DB_CYCLES + 1);
  localparam logic [DbW-1:0] DbLast = DbW'(DB_CYCLES - 1);

  logic [N-1:0]   s1_q, s2_q;
  logic [DbW-1:0] db_cnt_q [N];
  logic [DbW-1:0] db_cnt_d [N];
  logic [N-1:0]   level_q, level_d;
  logic [N-1:0]   press_q, press_d;
  logic [N-1:0]   rel_q, rel_d;

  // Synchronizer, debounce counters, level and edge pulses
  always_ff @(posedge clk) begin
    if (rst) begin
      s1_q    <= '0;
      s2_q    <= '0;
      level_q <= '0;
      press_q <= '0;
      rel_q   <= '0;
      for (int i = 0; i < int'(N); i++) db_cnt_q[i] <= '0;
    end else begin
      s1_q    <= raw_in ^ INV_MASK;
      s2_q    <= s1_q;
      level_q <= level_d;
      press_q <= press_d;
      rel_q   <= rel_d;
      for (int i = 0; i < int'(N); i++) db_cnt_q[i] <= db_cnt_d[i];
    end
  end

  // Count consecutive disagreeing samples; accept the new level on the last one
  always_comb begin
    level_d = level_q;
    press_d = '0;
    rel_d   = '0;
    for (int i = 0; i < int'(N); i++) begin
      db_cnt_d[i] = '0;
      if (s2_q[i] != level_q[i]) begin
        if (db_cnt_q[i] == DbLast) begin
          level_d[i] = ~level_q[i];
          press_d[i] = ~level_q[i];
          rel_d[i]   = level_q[i];
        end else begin
          db_cnt_d[i] = db_cnt_q[i] + DbW'(1);
        end
      end
    end
  end

  assign level_out     = level_q;
  assign press_pulse   = press_q;
  assign release_pulse = rel_q;

`ifdef DEBOUNCE_HOLD_EN
  localparam int unsigned HoldW = $clog2(HOLD_CYCLES + 1);
  localparam logic [HoldW-1:0] HoldMax  = HoldW'(HOLD_CYCLES);
  localparam logic [HoldW-1:0] HoldLast = HoldW'(HOLD_CYCLES - 1);

  logic [HoldW-1:0] hold_cnt_q [N];
  logic [HoldW-1:0] hold_cnt_d [N];
  logic [N-1:0]     hold_q, hold_d;
  logic [N-1:0]     hpulse_q, hpulse_d;

  // Hold counter and long-press flags
  always_ff @(posedge clk) begin
    if (rst) begin
      hold_q   <= '0;
      hpulse_q <= '0;
      for (int i = 0; i < int'(N); i++) hold_cnt_q[i] <= '0;
    end else begin
      hold_q   <= hold_d;
      hpulse_q <= hpulse_d;
      for (int i = 0; i < int'(N); i++) hold_cnt_q[i] <= hold_cnt_d[i];
    end
  end

  // Saturating count while active; a falling level clears on the release edge
  always_comb begin
    hold_d   = hold_q;
    hpulse_d = '0;
    for (int i = 0; i < int'(N); i++) begin
      hold_cnt_d[i] = hold_cnt_q[i];
      if (rel_d[i] || !level_q[i]) begin
        hold_cnt_d[i] = '0;
        hold_d[i]     = 1'b0;
      end else if (hold_cnt_q[i] != HoldMax) begin
        hold_cnt_d[i] = hold_cnt_q[i] + HoldW'(1);
        if (hold_cnt_q[i] == HoldLast) begin
          hold_d[i]   = 1'b1;
          hpulse_d[i] = 1'b1;
        end
      end
    end
  end

  assign hold_out   = hold_q;
  assign hold_pulse = hpulse_q;
`else
  assign hold_out   = '0;
  assign hold_pulse = '0;
`endif

endmodule

// File: tb/tb_debounce_bank.sv
// Self-checking bench for debounce_bank: directed scenarios plus random pin
// activity, every cycle compared against a timestamp-based reference model.
module tb_debounce_bank;

  localparam int unsigned N    = 4;
  localparam int unsigned Db   = 4;
  localparam int unsigned Hold = 16;
  localparam logic [3:0]  Inv  = 4'b0011;
  localparam logic [3:0]  Idle = 4'b0011;  // all channels inactive at the pins
`ifdef DEBOUNCE_HOLD_EN
  localparam bit HoldEn = 1'b1;
`else
  localparam bit HoldEn = 1'b0;
`endif

  logic       clk = 1'b0;
  logic       rst;
  logic [3:0] raw_in;
  logic [3:0] level_out, press_pulse, release_pulse, hold_out, hold_pulse;

  always #5 clk = ~clk;

  debounce_bank #(
    .N          (N),
    .DB_CYCLES  (Db),
    .HOLD_CYCLES(Hold),
    .INV_MASK   (Inv)
  ) dut (
    .clk          (clk),
    .rst          (rst),
    .raw_in       (raw_in),
    .level_out    (level_out),
    .press_pulse  (press_pulse),
    .release_pulse(release_pulse),
    .hold_out     (hold_out),
    .hold_pulse   (hold_pulse)
  );

  int n_checks = 0;
  int n_pass   = 0;

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h (t=%0t)", tag, got, exp, $time);
  endtask

  // Reference model: pin pipeline plus per-channel timestamps of the last
  // agreeing sample and of the last accepted rise.
  int         e = 0;
  logic [3:0] m_p1 = '0, m_p2 = '0, m_lvl = '0, m_prs = '0, m_rel = '0;
  logic [3:0] m_hold = '0, m_hp = '0;
  int         last_agree[4];
  int         rise_t[4];

  task automatic model_edge(input logic [3:0] r, input logic rs);
    logic old;
    e++;
    if (rs) begin
      m_p1 = '0; m_p2 = '0; m_lvl = '0; m_prs = '0; m_rel = '0; m_hold = '0; m_hp = '0;
      for (int i = 0; i < 4; i++) last_agree[i] = e;
    end else begin
      m_prs = '0; m_rel = '0; m_hp = '0;
      for (int i = 0; i < 4; i++) begin
        old = m_lvl[i];
        if (m_p2[i] == m_lvl[i]) begin
          last_agree[i] = e;
        end else if (e - last_agree[i] == int'(Db)) begin
          m_lvl[i] = ~old;
          last_agree[i] = e;
          if (old) m_rel[i] = 1'b1;
          else     m_prs[i] = 1'b1;
        end
        if (HoldEn) begin
          if (m_prs[i]) rise_t[i] = e;
          else if (m_rel[i] || !m_lvl[i]) m_hold[i] = 1'b0;
          else if (!m_hold[i] && e - rise_t[i] == int'(Hold)) begin
            m_hold[i] = 1'b1;
            m_hp[i]   = 1'b1;
          end
        end
      end
      m_p2 = m_p1;
      m_p1 = r ^ Inv;
    end
  endtask

  // Edge index (since the last mark) of the first pulse/event seen per channel
  int k = 0;
  int first_press[4], first_rel[4], first_hold[4], first_hclr[4];

  task automatic mark();
    k = 0;
    for (int i = 0; i < 4; i++) begin
      first_press[i] = 0; first_rel[i] = 0; first_hold[i] = 0; first_hclr[i] = 0;
    end
  endtask

  task automatic step(input logic [3:0] r, input logic rs);
    logic [3:0] hold_prev;
    hold_prev = hold_out;
    raw_in = r;
    rst    = rs;
    k++;
    @(posedge clk);
    model_edge(r, rs);
    @(negedge clk);
    check_eq("level_out", 32'(level_out), 32'(m_lvl));
    check_eq("press_pulse", 32'(press_pulse), 32'(m_prs));
    check_eq("release_pulse", 32'(release_pulse), 32'(m_rel));
    check_eq("hold_out", 32'(hold_out), 32'(m_hold));
    check_eq("hold_pulse", 32'(hold_pulse), 32'(m_hp));
    for (int i = 0; i < 4; i++) begin
      if (press_pulse[i] && first_press[i] == 0) first_press[i] = k;
      if (release_pulse[i] && first_rel[i] == 0) first_rel[i] = k;
      if (hold_pulse[i] && first_hold[i] == 0) first_hold[i] = k;
      if (hold_prev[i] === 1'b1 && !hold_out[i] && first_hclr[i] == 0) first_hclr[i] = k;
    end
  endtask

  initial begin
    logic [3:0] r;
    logic       rs;
    raw_in = Idle;
    rst    = 1'b1;
    for (int i = 0; i < 4; i++) begin
      last_agree[i] = 0;
      rise_t[i]     = 0;
    end

    // Reset with active-low pins idle-high, then press channel 0
    for (int i = 0; i < 3; i++) step(Idle, 1'b1);
    mark();
    for (int i = 0; i < 8; i++) step(4'b0010, 1'b0);
    check_eq("rst_press0_lat", 32'(first_press[0]), 32'd6);
    for (int i = 0; i < 8; i++) step(Idle, 1'b0);

    // Clean press/release on channel 2
    mark();
    for (int i = 0; i < 20; i++) step(4'b0111, 1'b0);
    check_eq("press2_lat", 32'(first_press[2]), 32'd6);
    mark();
    for (int i = 0; i < 10; i++) step(Idle, 1'b0);
    check_eq("release2_lat", 32'(first_rel[2]), 32'd6);

    // Glitch rejection on channel 3
    mark();
    for (int i = 0; i < 3; i++) step(4'b1011, 1'b0);
    step(Idle, 1'b0);
    for (int i = 0; i < 3; i++) step(4'b1011, 1'b0);
    for (int i = 0; i < 8; i++) step(Idle, 1'b0);
    check_eq("glitch3_press", 32'(first_press[3]), 32'd0);
    check_eq("glitch3_release", 32'(first_rel[3]), 32'd0);

    // Independence: channel 3 glitches low at edge 4
    mark();
    for (int i = 0; i < 3; i++) step(4'b1111, 1'b0);
    step(4'b0111, 1'b0);
    for (int i = 0; i < 10; i++) step(4'b1111, 1'b0);
    check_eq("indep_press2", 32'(first_press[2]), 32'd6);
    check_eq("indep_press3", 32'(first_press[3]), 32'd10);
    for (int i = 0; i < 10; i++) step(Idle, 1'b0);

    // Long press on channel 2
    mark();
    for (int i = 0; i < 40; i++) step(4'b0111, 1'b0);
    check_eq("hold2_lat", 32'(first_hold[2]), HoldEn ? 32'd22 : 32'd0);
    check_eq("hold2_level", 32'(hold_out[2]), 32'(HoldEn));
    mark();
    for (int i = 0; i < 10; i++) step(Idle, 1'b0);
    check_eq("hold2_release_lat", 32'(first_rel[2]), 32'd6);
    check_eq("hold2_clear_edge", 32'(first_hclr[2]), HoldEn ? 32'd6 : 32'd0);

    // Reset mid-debounce on channel 2
    mark();
    for (int i = 0; i < 3; i++) step(4'b0111, 1'b0);
    step(4'b0111, 1'b1);
    for (int i = 0; i < 10; i++) step(4'b0111, 1'b0);
    check_eq("rstmid_press2", 32'(first_press[2]), 32'd10);
    for (int i = 0; i < 10; i++) step(Idle, 1'b0);

    // Random pin activity with occasional resets
    r = Idle;
    for (int c = 0; c < 1500; c++) begin
      for (int i = 0; i < 4; i++)
        if ($urandom_range(0, 9) == 0) r[i] = ~r[i];
      rs = ($urandom_range(0, 249) == 0);
      step(r, rs);
    end

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule

// File: doc/debounce_bank.md
# debounce_bank

Parametrised multi-channel debouncer for push-buttons, keypad columns and slide switches. Each channel has its own debounce counter, so activity on one input never restarts another. Per channel it produces a clean level, one-cycle press and release pulses, and a long-press indication. It sits between the board pins and the datapath, replacing the earlier single-counter button/switch filter.

## Interface

Parameters:
- `N`, 20, number of input channels (≥1).
- `DB_CYCLES`, 100000, consecutive stable samples required to accept a new level (≥1).
- `HOLD_CYCLES`, 200000000, cycles of continuous active level before long-press asserts (≥1).
- `INV_MASK`, {N{1'b0}}, per-channel inversion; bit=1 marks an active-low pin.

Ports:
- `clk`  in  1  system clock.
- `rst`  in  1  synchronous, active-high reset.
- `raw_in`  in  N  asynchronous pin inputs.
- `level_out`  out  N  debounced active-high level.
- `press_pulse`  out  N  one-cycle pulse on accepted 0→1.
- `release_pulse`  out  N  one-cycle pulse on accepted 1→0.
- `hold_out`  out  N  long-press level.
- `hold_pulse`  out  N  one-cycle pulse when `hold_out` rises.

## Operation

- **Conditioning:** `x = raw_in ^ INV_MASK` passes through a two-flop synchronizer (`s1`, `s2`) per channel.
- **Debounce counter:** each channel has an independent counter of width `$clog2(DB_CYCLES+1)`.
  - `s2 == level_out[i]`: counter clears to 0.
  - `s2 != level_out[i]` and counter < `DB_CYCLES-1`: counter increments.
  - `s2 != level_out[i]` and counter == `DB_CYCLES-1`: `level_out[i]` toggles, counter clears, and the matching `press_pulse[i]` or `release_pulse[i]` asserts for exactly one cycle.
- **Glitches:** any single agreeing sample restarts the count from 0. A glitch shorter than `DB_CYCLES` samples never reaches `level_out`.
- **Hold counter:** each channel also has a hold counter of width `$clog2(HOLD_CYCLES+1)`.
  - Counts while `level_out[i]==1` and saturates at `HOLD_CYCLES`.
  - On the edge where it reaches `HOLD_CYCLES`, `hold_out[i]` sets and `hold_pulse[i]` asserts for one cycle.
  - On the edge where `level_out[i]` falls, the hold counter and `hold_out[i]` clear in the same cycle as `release_pulse[i]`.
- **Channel independence:** simultaneous transitions on several channels are filtered fully independently. Multiple pulse bits may assert in the same cycle.
- **Reset:** sync flops, all counters, `level_out`, both pulse buses, `hold_out` and `hold_pulse` all go to 0. An input already active when reset releases produces a `press_pulse` once it is debounced, as a normal transition.
- **Reset mid-debounce or mid-hold:** all progress is discarded and no pulse is emitted.

## Timing

- Number edges from the first edge that samples a new, stable `raw_in` value as edge 1.
  - `s1` is valid after edge 1 and `s2` after edge 2.
  - Edges 3 … `DB_CYCLES+2` take `DB_CYCLES` mismatching samples.
  - `level_out` and the edge pulse change on edge `DB_CYCLES+2`.
- Total press latency is `DB_CYCLES+2` cycles. Release latency is identical.
- `hold_out` and `hold_pulse` assert exactly `HOLD_CYCLES` edges after the edge on which `level_out` rose.
- Pulses are always exactly one cycle wide. A channel never produces more than one press or release pulse per accepted transition.
- All outputs are registered. There is no combinational path from `raw_in` to any output.

## Configuration

- **`DEBOUNCE_HOLD_EN` defined:** hold counters exist and `hold_out`/`hold_pulse` behave as described.
- **`DEBOUNCE_HOLD_EN` undefined:**
  - Hold counters are not instantiated.
  - `hold_out` and `hold_pulse` are tied to constant 0.
  - All other behaviour and timing are unchanged.

## Test plan

Bench parameters: `N=4`, `DB_CYCLES=4`, `HOLD_CYCLES=16`, `INV_MASK=4'b0011`, `DEBOUNCE_HOLD_EN` defined unless a scenario says otherwise.

- **Clean press/release:** `raw_in[2]` 0→1 held 20 cycles, then 1→0.
  - `level_out[2]` rises on edge 6 with one-cycle `press_pulse[2]`.
  - It falls 6 edges after the release, with one-cycle `release_pulse[2]`.
- **Glitch rejection:** `raw_in[3]` pulses high for 3 cycles, returns low for 1 cycle, then high for 3 cycles. `level_out[3]` stays 0 and no pulses fire.
- **Active-low and reset:** `raw_in=4'b0011` throughout reset.
  - All outputs are 0 during reset.
  - After reset, `raw_in[0]` 1→0 gives `press_pulse[0]` 6 edges later.
- **Independence:** `raw_in[2]` and `raw_in[3]` rise together, then `raw_in[3]` glitches low for 1 cycle at edge 4.
  - `press_pulse[2]` fires at edge 6.
  - `press_pulse[3]` fires at edge 10 (4 + 6).
- **Long press:** `raw_in[2]` held high 40 cycles.
  - `hold_pulse[2]` fires 16 edges after `level_out[2]` rises, and `hold_out[2]` holds 1.
  - On release, `hold_out[2]` clears on the same edge as `release_pulse[2]`.
  - With `DEBOUNCE_HOLD_EN` undefined, `hold_out` and `hold_pulse` stay 0.
- **Reset mid-debounce:** assert `rst` at edge 4 of a press on `raw_in[2]`, deassert at edge 5. No `press_pulse` at edge 6; the pulse appears 6 edges after reset release.
